// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI-to-SRAM slave: FSM state encoding,
// SRAM geometry default and the idle (no-write) byte-enable pattern.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

package axi_sram_pkg;

    localparam int          SRAM_AW_DEF = 14;
    localparam logic [3:0]  WEB_IDLE    = 4'hF;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        R_ACC  = 3'd1,
        R_DATA = 3'd2,
        W_DATA = 3'd3,
        W_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/axi_sram_slave.sv
// AXI slave front-end for a single-port synchronous SRAM (32-bit words).
// One transaction in flight; reads take two cycles per beat, writes one.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int SRAM_AW = SRAM_AW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    // AR channel
    input  logic [`AXI_IDS_BITS-1:0] ARID,
    input  logic [31:0]              ARADDR,
    input  logic [3:0]               ARLEN,
    input  logic [2:0]               ARSIZE,
    input  logic [1:0]               ARBURST,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    // R channel
    output logic [`AXI_IDS_BITS-1:0] RID,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic                     RLAST,
    output logic                     RVALID,
    input  logic                     RREADY,
    // AW channel
    input  logic [`AXI_IDS_BITS-1:0] AWID,
    input  logic [31:0]              AWADDR,
    input  logic [3:0]               AWLEN,
    input  logic [2:0]               AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    // W channel
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    // B channel
    output logic [`AXI_IDS_BITS-1:0] BID,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    // SRAM side
    output logic                     CS,
    output logic                     OE,
    output logic [3:0]               WEB,
    output logic [SRAM_AW-1:0]       A,
    output logic [31:0]              DI,
    input  logic [31:0]              DO
);

    state_t                   r_state;
    logic                     r_last_wr;
    logic [`AXI_IDS_BITS-1:0] r_id;
    logic [3:0]               r_len;
    logic [3:0]               r_cnt;
    logic [SRAM_AW-1:0]       r_addr;

    logic w_idle;
    logic w_grant_rd;
    logic w_grant_wr;
    logic w_w_hs;
    logic w_r_last;
    logic w_unused;

    // Tie-break favours whichever side was not served last.
    assign w_idle     = (r_state == IDLE);
    assign w_grant_rd = w_idle && ARVALID && (!AWVALID || r_last_wr);
    assign w_grant_wr = w_idle && AWVALID && (!ARVALID || !r_last_wr);
    assign w_w_hs     = (r_state == W_DATA) && WVALID;
    assign w_r_last   = (r_cnt == r_len);

    assign w_unused = ^{ARADDR[31:SRAM_AW+2], ARADDR[1:0], ARSIZE, ARBURST,
                        AWADDR[31:SRAM_AW+2], AWADDR[1:0], AWSIZE, AWBURST, AWLEN};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last_wr <= 1'b1;
            r_id      <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_addr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_rd) begin
                        r_id      <= ARID;
                        r_len     <= ARLEN;
                        r_cnt     <= '0;
                        r_addr    <= ARADDR[SRAM_AW+1:2];
                        r_last_wr <= 1'b0;
                        r_state   <= R_ACC;
                    end else if (w_grant_wr) begin
                        r_id      <= AWID;
                        r_addr    <= AWADDR[SRAM_AW+1:2];
                        r_last_wr <= 1'b1;
                        r_state   <= W_DATA;
                    end
                end
                R_ACC: r_state <= R_DATA;
                R_DATA: begin
                    if (RREADY) begin
                        if (w_r_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= R_ACC;
                        end
                    end
                end
                W_DATA: begin
                    // Burst length follows WLAST; AWLEN is not trusted.
                    if (WVALID) begin
                        r_addr <= r_addr + 1'b1;
                        if (WLAST) r_state <= W_RESP;
                    end
                end
                W_RESP: if (BREADY) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ARREADY = w_grant_rd;
        AWREADY = w_grant_wr;
        RVALID  = 1'b0;
        RID     = '0;
        RDATA   = '0;
        RRESP   = RESP_OKAY;
        RLAST   = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BID     = '0;
        BRESP   = RESP_OKAY;
        CS      = 1'b0;
        OE      = 1'b0;
        WEB     = WEB_IDLE;
        A       = '0;
        DI      = '0;
        case (r_state)
            R_ACC: begin
                CS = 1'b1;
                OE = 1'b1;
                A  = r_addr;
            end
            R_DATA: begin
                // Address and strobes stay up so DO is re-read unchanged under stall.
                CS     = 1'b1;
                OE     = 1'b1;
                A      = r_addr;
                RVALID = 1'b1;
                RID    = r_id;
                RDATA  = DO;
                RLAST  = w_r_last;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (w_w_hs) begin
                    CS  = 1'b1;
                    A   = r_addr;
                    DI  = WDATA;
                    WEB = ~WSTRB;
                end
            end
            W_RESP: begin
                BVALID = 1'b1;
                BID    = r_id;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave with a behavioural SRAM attached.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

module tb_axi_sram_slave;
    import axi_sram_pkg::*;

    localparam int AW  = 14;
    localparam int IDW = `AXI_IDS_BITS;

    logic clk, rst;
    logic [IDW-1:0] ARID, AWID, RID, BID;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA, DI, DO;
    logic [3:0]  ARLEN, AWLEN, WSTRB, WEB;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic ARVALID, ARREADY, RLAST, RVALID, RREADY, AWVALID, AWREADY;
    logic WLAST, WVALID, WREADY, BVALID, BREADY, CS, OE;
    logic [AW-1:0] A;

    axi_sram_slave #(.SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    typedef struct {
        logic [31:0]    data;
        logic [IDW-1:0] id;
        logic           last;
        logic [AW-1:0]  addr;
    } rexp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    web;
        logic [31:0]   di;
    } wexp_t;

    rexp_t          r_q[$];
    wexp_t          w_q[$];
    logic [IDW-1:0] b_q[$];
    int             rhs_cyc[$];

    logic [31:0] mem     [0:(1<<AW)-1];
    logic [31:0] exp_mem [0:(1<<AW)-1];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural SRAM: read data appears one cycle after the address.
    initial DO = '0;
    always @(posedge clk) begin
        if (CS && OE) DO <= mem[A];
        if (CS) begin
            for (int b = 0; b < 4; b++)
                if (!WEB[b]) mem[A][b*8 +: 8] <= DI[b*8 +: 8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        rexp_t e;
        if (!rst && RVALID && RREADY) begin
            rhs_cyc.push_back(cyc);
            check("r_expected", r_q.size() > 0, 1);
            if (r_q.size() > 0) begin
                e = r_q.pop_front();
                check("rdata", RDATA, e.data);
                check("rid", RID, e.id);
                check("rlast", RLAST, e.last);
                check("rresp", RRESP, 0);
                check("r_addr", A, e.addr);
            end
        end
    end

    always @(negedge clk) begin
        wexp_t e;
        if (!rst && CS && !OE) begin
            check("wr_expected", w_q.size() > 0, 1);
            if (w_q.size() > 0) begin
                e = w_q.pop_front();
                check("wr_addr", A, e.addr);
                check("wr_web", WEB, e.web);
                check("wr_di", DI, e.di);
            end
        end
    end

    always @(negedge clk) begin
        logic [IDW-1:0] e;
        if (!rst && BVALID && BREADY) begin
            check("b_expected", b_q.size() > 0, 1);
            if (b_q.size() > 0) begin
                e = b_q.pop_front();
                check("bid", BID, e);
                check("bresp", BRESP, 0);
            end
        end
    end

    // ---------------- expectation helpers ----------------
    task automatic exp_read(input logic [IDW-1:0] id, input logic [31:0] addr, input int len);
        logic [AW-1:0] w;
        rexp_t e;
        w = addr[AW+1:2];
        for (int i = 0; i <= len; i++) begin
            e.data = exp_mem[w];
            e.id   = id;
            e.last = (i == len);
            e.addr = w;
            r_q.push_back(e);
            w = w + 1'b1;
        end
    endtask

    task automatic exp_write(input logic [AW-1:0] word, input logic [31:0] data, input logic [3:0] strb);
        wexp_t e;
        e.addr = word;
        e.web  = ~strb;
        e.di   = data;
        w_q.push_back(e);
        for (int b = 0; b < 4; b++)
            if (strb[b]) exp_mem[word][b*8 +: 8] = data[b*8 +: 8];
    endtask

    // ---------------- drivers ----------------
    task automatic ar_send(input logic [IDW-1:0] id, input logic [31:0] addr, input int len);
        bit ok;
        exp_read(id, addr, len);
        ARID = id; ARADDR = addr; ARLEN = len[3:0]; ARVALID = 1'b1;
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ARREADY) begin ok = 1; break; end
        end
        check("ar_accept", ok, 1);
        @(posedge clk); #1;
        ARVALID = 1'b0;
    endtask

    task automatic aw_send(input logic [IDW-1:0] id, input logic [31:0] addr);
        bit ok;
        AWID = id; AWADDR = addr; AWLEN = 4'd3; AWVALID = 1'b1;
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (AWREADY) begin ok = 1; break; end
        end
        check("aw_accept", ok, 1);
        @(posedge clk); #1;
        AWVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                          input logic [AW-1:0] word);
        bit ok;
        exp_write(word, data, strb);
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (WREADY) begin ok = 1; break; end
        end
        check("w_accept", ok, 1);
        @(posedge clk); #1;
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 200; k++) begin
            if (r_q.size() == 0 && w_q.size() == 0 && b_q.size() == 0) break;
            @(negedge clk);
        end
        check(name, r_q.size() + w_q.size() + b_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 32'hA500_0000 + i;
            exp_mem[i] = 32'hA500_0000 + i;
        end
        rst = 1'b1;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        RREADY = 1'b1; BREADY = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_cs", CS, 0);
        check("rst_web", WEB, 4'hF);
        check("rst_rvalid", RVALID, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_readies", {ARREADY, AWREADY, WREADY}, 3'b000);
        check("idle_valids", {RVALID, BVALID, RLAST}, 3'b000);
        check("idle_ids", {RID, BID}, 0);
        check("idle_sram", {CS, OE, WEB}, 6'b00_1111);
        check("idle_a_di", {A, DI}, 0);
        check("idle_rdata", RDATA, 0);
        @(posedge clk); #1;

        // Tie from reset: read first, then a repeated tie goes to write.
        exp_read(8'd1, 32'h40, 0);
        ARID = 8'd1; ARADDR = 32'h40; ARLEN = 4'd0; ARVALID = 1'b1;
        AWID = 8'd2; AWADDR = 32'h80; AWVALID = 1'b1;
        @(negedge clk);
        check("tie1_arready", ARREADY, 1);
        check("tie1_awready", AWREADY, 0);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        exp_read(8'd3, 32'h44, 0);
        ARID = 8'd3; ARADDR = 32'h44; ARVALID = 1'b1;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ARREADY || AWREADY) begin ok = 1; break; end
        end
        check("tie2_seen", ok, 1);
        check("tie2_awready", AWREADY, 1);
        check("tie2_arready", ARREADY, 0);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        b_q.push_back(8'd2);
        w_beat(32'hCAFE_F00D, 4'hF, 1'b1, 14'd32);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ARREADY) begin ok = 1; break; end
        end
        check("tie2_read_after", ok, 1);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        wait_drain("drain_tie");

        // Four-beat read from words 4..7, two cycles per beat.
        rhs_cyc.delete();
        ar_send(8'h5A, 32'h0000_0010, 3);
        wait_drain("drain_rd4");
        check("rd4_beats", rhs_cyc.size(), 4);
        for (int i = 1; i < rhs_cyc.size(); i++)
            check("rd4_gap", rhs_cyc[i] - rhs_cyc[i-1], 2);

        // Partial-strobe write burst, then read back the merged words.
        aw_send(8'd5, 32'h0000_0020);
        b_q.push_back(8'd5);
        w_beat(32'h1122_3344, 4'b0011, 1'b0, 14'd8);
        w_beat(32'h5566_7788, 4'b1111, 1'b1, 14'd9);
        wait_drain("drain_wr2");
        check("wr2_merge_model", exp_mem[8], 32'hA500_3344);
        ar_send(8'd6, 32'h0000_0020, 1);
        wait_drain("drain_rb2");

        // Zero-strobe beat: handshake but no byte write, address still advances.
        aw_send(8'd7, 32'h0000_0190);
        b_q.push_back(8'd7);
        w_beat(32'hDEAD_BEEF, 4'b0000, 1'b0, 14'd100);
        w_beat(32'h9900_0000, 4'b1000, 1'b1, 14'd101);
        wait_drain("drain_wr0");
        ar_send(8'd8, 32'h0000_0190, 1);
        wait_drain("drain_rb0");

        // Address wrap at the top of the SRAM.
        ar_send(8'd9, 32'h0000_FFFC, 1);
        wait_drain("drain_wrap");

        // Back-pressure on beat 0: outputs frozen for five cycles.
        RREADY = 1'b0;
        ar_send(8'd7, 32'h0000_0100, 1);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (RVALID) begin ok = 1; break; end
            @(negedge clk);
        end
        check("stall_rvalid_seen", ok, 1);
        for (int k = 0; k < 5; k++) begin
            check("stall_rvalid", RVALID, 1);
            check("stall_rdata", RDATA, exp_mem[64]);
            check("stall_rid", RID, 8'd7);
            check("stall_rlast", RLAST, 0);
            check("stall_a", A, 14'd64);
            @(negedge clk);
        end
        @(posedge clk); #1;
        RREADY = 1'b1;
        wait_drain("drain_stall");

        // Reset mid-burst after one of four beats.
        aw_send(8'd4, 32'h0000_0200);
        w_beat(32'h0BAD_F00D, 4'hF, 1'b0, 14'd128);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_wready", WREADY, 0);
        check("abort_web", WEB, 4'hF);
        check("abort_cs", CS, 0);
        check("abort_bvalid", BVALID, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_no_b", BVALID, 0);
        end
        @(posedge clk); #1;
        ar_send(8'd6, 32'h0000_0200, 1);
        wait_drain("drain_abort");

        check("final_rq", r_q.size(), 0);
        check("final_wq", w_q.size(), 0);
        check("final_bq", b_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter: SRAM_AW, default 14, SRAM word-address width (16K x 32-bit words).
REQ-002 Port: clk  in  1  single clock; all logic rising-edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Ports: AR channel, AXI slave side: ARID in `AXI_IDS_BITS; ARADDR in 32; ARLEN in 4; ARSIZE in 3; ARBURST in 2; ARVALID in 1; ARREADY out 1.
REQ-005 Ports: R channel: RID out `AXI_IDS_BITS; RDATA out 32; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1.
REQ-006 Ports: AW channel: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID in; AWREADY out; widths as AR.
REQ-007 Ports: W channel: WDATA in 32; WSTRB in 4; WLAST in 1; WVALID in 1; WREADY out 1.
REQ-008 Ports: B channel: BID out `AXI_IDS_BITS; BRESP out 2; BVALID out 1; BREADY in 1.
REQ-009 Ports: SRAM side: CS out 1, OE out 1, WEB out 4 (active-low byte write), A out SRAM_AW, DI out 32, DO in 32 (valid one cycle after A presented with CS=1, OE=1).

Function
REQ-010 FSM states: IDLE, R_ACC, R_DATA, W_DATA, W_RESP; one transaction in flight at any time.
REQ-011 IDLE: ARREADY=1 when granted read, AWREADY=1 when granted write; never both in the same cycle.
REQ-012 Arbitration: only one valid -> it wins; both valid -> side not served last wins; last-served flag updates on every AR or AW handshake.
REQ-013 AR handshake: latch ARID, ARLEN, word address ARADDR[SRAM_AW+1:2]; beat counter=0; next state R_ACC.
REQ-014 R_ACC (one cycle): CS=1, OE=1, A=current address; next state R_DATA.
REQ-015 R_DATA: RVALID=1, RDATA=DO, RID=latched ID, RRESP=2'b00, RLAST=(beat counter==latched LEN); A, CS, OE held so DO stays stable while RREADY=0.
REQ-016 R handshake, not last: address+1, counter+1, to R_ACC (2 cycles per beat). Last: to IDLE.
REQ-017 AW handshake: latch AWID, word address; next state W_DATA.
REQ-018 W_DATA: WREADY=1; on W handshake same cycle CS=1, A=current address, DI=WDATA, WEB=~WSTRB; address+1.
REQ-019 W handshake with WLAST=1: to W_RESP; burst length is set by WLAST, AWLEN ignored.
REQ-020 W_RESP: BVALID=1, BID=latched ID, BRESP=2'b00; on BREADY to IDLE.
REQ-021 Outside a write beat WEB=4'hF; outside R_ACC/R_DATA/write beat CS=0, OE=0.
REQ-022 Address increment wraps modulo 2^SRAM_AW; ARADDR/AWADDR bits above SRAM_AW+1 and [1:0] ignored.
REQ-023 ARSIZE/AWSIZE, ARBURST/AWBURST ignored; all beats are 32-bit INCR.
REQ-024 WSTRB=4'h0 beat: handshake completes, WEB=4'hF, address still increments.
REQ-025 RVALID, BVALID, once asserted, stay high with payload stable until handshake.

Reset
REQ-026 rst=1 at a clock edge: state IDLE; last-served flag = write (read wins first tie); counters/latches 0.
REQ-027 During and after reset until first transaction: all READY/VALID=0 except IDLE readies per REQ-011, RLAST=0, IDs/data/resp 0, CS=0, OE=0, WEB=4'hF, A=0, DI=0.
REQ-028 rst asserted mid-transaction aborts it at that edge; no further SRAM write, no R or B response issued.

Structure
REQ-029 Widths come from the shared AXI_define.svh macros; FSM state enum and SRAM constants (SRAM_AW default, WEB_IDLE) live in shared package axi_sram_pkg.
REQ-030 Single flat module; the SRAM macro is instantiated outside, by the parent wrapper, and is not a sub-module.

Verification
REQ-031 ARADDR=0x0000_0010, ARLEN=3, RREADY=1 -> four beats from words 4..7, RLAST only on 4th, RID=ARID, 2 cycles per beat.
REQ-032 AWADDR=0x0000_0020, 2 beats WSTRB=4'b0011 then 4'b1111, WLAST on 2nd -> WEB=4'b1100 at A=8, 4'b0000 at A=9; one BVALID, BRESP=0.
REQ-033 ARVALID and AWVALID both high from reset idle -> read first, then write; repeat tie -> write first.
REQ-034 Read, ARADDR=0x0000_FFFC, ARLEN=1 -> A goes 0x3FFF then 0x0000.
REQ-035 RREADY low 5 cycles on beat 0 -> RDATA, RID, RLAST, A stable throughout; no address advance.
REQ-036 rst pulsed during W_DATA after 1 of 4 beats -> IDLE next cycle, WEB=4'hF, no BVALID; new read then completes normally.
